// File: rtl/mult_arbiter.sv
// Two-requester round-robin front end for a shared multi-cycle multiplier.
// Holds the multiplier in reset until operands are latched, then counts out its latency.
module mult_arbiter #(
    parameter int LATENCY = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    input  logic               req1_valid,
    output logic               req0_ready,
    output logic               req1_ready,
    input  logic signed [31:0] req0_a,
    input  logic signed [31:0] req0_b,
    input  logic signed [31:0] req1_a,
    input  logic signed [31:0] req1_b,
    output logic               resp0_valid,
    output logic               resp1_valid,
    input  logic               resp0_ready,
    input  logic               resp1_ready,
    output logic signed [63:0] resp_product,
    output logic               mul_rst,
    output logic signed [31:0] mul_multiplier,
    output logic signed [31:0] mul_multiplicand,
    input  logic signed [63:0] mul_product
);

    localparam int CW = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               last_grant_q, last_grant_d;
    logic               gid_q, gid_d;
    logic signed [31:0] op_a_q, op_a_d;
    logic signed [31:0] op_b_q, op_b_d;
    logic signed [63:0] prod_q, prod_d;
    logic               grant0, grant1;
    logic               resp_ack;

    // On a tie the requester that was not served last wins.
    assign grant0 = (state_q == IDLE) && req0_valid && (!req1_valid || last_grant_q);
    assign grant1 = (state_q == IDLE) && req1_valid && (!req0_valid || !last_grant_q);

    assign req0_ready       = grant0;
    assign req1_ready       = grant1;
    assign resp0_valid      = (state_q == DONE) && !gid_q;
    assign resp1_valid      = (state_q == DONE) && gid_q;
    assign resp_product     = prod_q;
    assign mul_multiplier   = op_a_q;
    assign mul_multiplicand = op_b_q;
    assign mul_rst          = (state_q == IDLE) || (state_q == LOAD);
    assign resp_ack         = gid_q ? resp1_ready : resp0_ready;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        gid_d        = gid_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        prod_d       = prod_q;
        case (state_q)
            IDLE: begin
                if (grant0) begin
                    op_a_d       = req0_a;
                    op_b_d       = req0_b;
                    gid_d        = 1'b0;
                    last_grant_d = 1'b0;
                    state_d      = LOAD;
                end else if (grant1) begin
                    op_a_d       = req1_a;
                    op_b_d       = req1_b;
                    gid_d        = 1'b1;
                    last_grant_d = 1'b1;
                    state_d      = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                // Counter saturates at the capture point so it can never wrap.
                if (cnt_q == CNT_LAST) begin
                    prod_d  = mul_product;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (resp_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            gid_q        <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            prod_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            gid_q        <= gid_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            prod_q       <= prod_d;
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter with a behavioural latency-accurate multiplier model.
module tb_mult_arbiter;

    localparam int LAT = 12;

    logic               clk = 1'b0;
    logic               rst;
    logic               req0_valid, req1_valid, req0_ready, req1_ready;
    logic signed [31:0] req0_a, req0_b, req1_a, req1_b;
    logic               resp0_valid, resp1_valid, resp0_ready, resp1_ready;
    logic signed [63:0] resp_product;
    logic               mul_rst;
    logic signed [31:0] mul_multiplier, mul_multiplicand;
    logic signed [63:0] mul_product;

    mult_arbiter #(.LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
        .resp0_ready(resp0_ready), .resp1_ready(resp1_ready),
        .resp_product(resp_product), .mul_rst(mul_rst),
        .mul_multiplier(mul_multiplier), .mul_multiplicand(mul_multiplicand),
        .mul_product(mul_product)
    );

    always #5 clk = ~clk;

    // Multiplier model: product is only correct once mul_rst has been low for LAT cycles.
    logic [5:0]         mcnt;
    logic signed [63:0] ea, eb;
    always @(posedge clk) begin
        if (mul_rst) mcnt <= '0;
        else if (mcnt != 6'd63) mcnt <= mcnt + 6'd1;
    end
    assign ea = mul_multiplier;
    assign eb = mul_multiplicand;
    assign mul_product = (!mul_rst && mcnt >= 6'(LAT - 1)) ? ea * eb : 64'hDEADBEEFDEADBEEF;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          id;
        logic [63:0] prod;
        int          vcyc;
    } exp_t;

    exp_t sb[$];
    bit   grant_log[$];
    int   gcyc[2];
    int   outstanding = 0;
    int   n_tests = 0, n_fail = 0;
    int   both_rdy = 0, dual_resp = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: pops on the first cycle a response appears, checks stability at acceptance.
    bit          pv0 = 0, pv1 = 0;
    logic [63:0] cur_prod;
    always @(negedge clk) begin
        if (rst) begin
            pv0 = 0;
            pv1 = 0;
        end else begin
            if (req0_ready && req1_ready) both_rdy++;
            if (resp0_valid && resp1_valid) dual_resp++;
            if ((resp0_valid && !pv0) || (resp1_valid && !pv1)) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", {63'd0, resp1_valid}, {63'd0, ~resp0_valid});
                    chk("unexpected_resp_any", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_id", {63'd0, resp1_valid}, {63'd0, e.id});
                    chk("resp_product", resp_product, e.prod);
                    chk("resp_latency", 64'(cyc), 64'(e.vcyc));
                    cur_prod = e.prod;
                end
            end
            if ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready)) begin
                chk("prod_at_accept", resp_product, cur_prod);
                outstanding--;
            end
            pv0 = resp0_valid;
            pv1 = resp1_valid;
        end
    end

    task automatic issue(input bit id, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input bit track);
        bit ok;
        ok = 0;
        if (id) begin req1_valid = 1; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1; req0_a = a; req0_b = b; end
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) begin ok = 1; break; end
        end
        if (ok) begin
            exp_t e;
            e.id = id; e.prod = exp; e.vcyc = cyc + LAT + 2;
            if (track) begin sb.push_back(e); outstanding++; end
            grant_log.push_back(id);
            gcyc[id] = cyc;
        end else begin
            chk("grant_timeout", 64'd0, 64'd1);
        end
        @(posedge clk);
        #1;
        if (id) req1_valid = 0; else req0_valid = 0;
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (outstanding == 0) begin ok = 1; break; end
        end
        if (!ok) chk("drain_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit          exp_order[4];
        int          bad_p, bad_r, bad_g, bad_v, rel_cyc, late_resp;
        logic [63:0] held;

        rst = 1; req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        resp0_ready = 1; resp1_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mul_rst", {63'd0, mul_rst}, 64'd1);
        chk("rst_product", resp_product, 64'd0);
        chk("rst_operand", {mul_multiplier, mul_multiplicand}, 64'd0);
        chk("rst_resp_valid", {62'd0, resp1_valid, resp0_valid}, 64'd0);
        req1_valid = 1;
        #1;
        chk("rst_single_ready", {62'd0, req1_ready, req0_ready}, 64'd2);
        req0_valid = 1;
        #1;
        chk("rst_tie_ready", {62'd0, req1_ready, req0_ready}, 64'd1);
        req0_valid = 0; req1_valid = 0;
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;

        // Simultaneous requests straight after reset: req0 wins the first tie.
        grant_log.delete();
        fork
            issue(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd1, 1);
            issue(1, 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF00000001, 1);
        join
        drain();
        chk("sim_order_0", {63'd0, grant_log[0]}, 64'd0);
        chk("sim_order_1", {63'd0, grant_log[1]}, 64'd1);

        // Fairness: both keep requesting.
        grant_log.delete();
        fork
            begin
                issue(0, 32'd3, 32'd5, 64'd15, 1);
                issue(0, 32'd100000, 32'd100000, 64'h00000002540BE400, 1);
            end
            begin
                issue(1, 32'hFFFFFFF9, 32'd6, 64'hFFFFFFFFFFFFFFD6, 1);
                issue(1, 32'h00010000, 32'h00010000, 64'h0000000100000000, 1);
            end
        join
        drain();
        exp_order = '{0, 1, 0, 1};
        for (int i = 0; i < 4; i++) chk($sformatf("fair_order_%0d", i), {63'd0, grant_log[i]}, {63'd0, exp_order[i]});

        // Single request with hand-computed product and exact latency.
        issue(0, 32'h12345678, 32'h12345678, 64'h014B66DC1DF4D840, 1);
        chk("operands_latched", {mul_multiplier, mul_multiplicand}, 64'h1234567812345678);
        drain();

        // Backpressure on resp1 with req0 waiting behind it.
        bad_p = 0; bad_r = 0; bad_g = 0; bad_v = 0; rel_cyc = 0;
        resp1_ready = 0;
        fork
            begin
                issue(1, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFFFFFFFFEB, 1);
                issue(0, 32'd2, 32'd9, 64'd18, 1);
            end
            begin
                bit seen;
                seen = 0;
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (resp1_valid) begin seen = 1; break; end
                end
                if (!seen) chk("bp_valid_timeout", 64'd0, 64'd1);
                held = resp_product;
                repeat (20) begin
                    @(negedge clk);
                    if (resp_product !== held) bad_p++;
                    if (mul_rst) bad_r++;
                    if (req0_ready) bad_g++;
                    if (!resp1_valid) bad_v++;
                end
                @(posedge clk);
                #1;
                resp1_ready = 1;
                rel_cyc = cyc;
            end
        join
        drain();
        chk("bp_prod_stable", 64'(bad_p), 64'd0);
        chk("bp_mul_rst_low", 64'(bad_r), 64'd0);
        chk("bp_no_grant", 64'(bad_g), 64'd0);
        chk("bp_valid_held", 64'(bad_v), 64'd0);
        chk("bp_next_grant_cycle", 64'(gcyc[0]), 64'(rel_cyc + 1));

        // MIN_INT times -1.
        issue(1, 32'h80000000, 32'hFFFFFFFF, 64'h0000000080000000, 1);
        drain();

        // Reset while RUN has counted to 5: the result must be discarded.
        issue(0, 32'd5, 32'd5, 64'd25, 0);
        repeat (6) @(posedge clk);
        #1;
        rst = 1;
        #1;
        chk("midrun_mul_rst", {63'd0, mul_rst}, 64'd1);
        chk("midrun_product", resp_product, 64'd0);
        chk("midrun_operand", {mul_multiplier, mul_multiplicand}, 64'd0);
        @(negedge clk);
        rst = 0;
        late_resp = 0;
        repeat (30) begin
            @(negedge clk);
            if (resp0_valid || resp1_valid) late_resp++;
        end
        chk("midrun_no_resp", 64'(late_resp), 64'd0);

        chk("no_dual_ready", 64'(both_rdy), 64'd0);
        chk("no_dual_resp", 64'(dual_resp), 64'd0);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 The module SHALL have parameter LATENCY, default 12, which is the number of cycles from multiplier reset deassertion until mul_product is valid.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The module SHALL have ports req0_valid and req1_valid, input, 1 bit each: requester n presents an operand pair.
REQ-005 The module SHALL have ports req0_ready and req1_ready, output, 1 bit each: requester n is granted this cycle.
REQ-006 The module SHALL have ports req0_a, req0_b, req1_a and req1_b, input, signed 32 bits each: multiplier and multiplicand operands.
REQ-007 The module SHALL have ports resp0_valid and resp1_valid, output, 1 bit each: the result for requester n is available.
REQ-008 The module SHALL have ports resp0_ready and resp1_ready, input, 1 bit each: requester n accepts its result.
REQ-009 The module SHALL have port resp_product, output, signed 64 bits: the captured product, shared by both requesters.
REQ-010 The module SHALL have port mul_rst, output, 1 bit: drives rst of the shared radix-8 multiplier.
REQ-011 The module SHALL have ports mul_multiplier and mul_multiplicand, output, signed 32 bits each: drive the multiplier operands.
REQ-012 The module SHALL have port mul_product, input, signed 64 bits: the multiplier result.

Function
REQ-013 The FSM SHALL have exactly four states, IDLE, LOAD, RUN and DONE, encoded in registers.
REQ-014 req0_ready and req1_ready SHALL be 0 in every state except IDLE.
REQ-015 In IDLE, if only one reqn_valid is 1, that requester's reqn_ready SHALL be 1.
REQ-016 In IDLE, if both reqn_valid are 1, reqn_ready SHALL go to the requester not served last (round-robin on a last_grant bit).
REQ-017 reqn_ready SHALL never be 1 for both requesters in the same cycle.
REQ-018 On a handshake (reqn_valid and reqn_ready both 1), the block SHALL latch that requester's a/b into the operand registers, record the grant id, update last_grant, and go IDLE->LOAD.
REQ-019 The operand registers SHALL drive mul_multiplier and mul_multiplicand continuously, and those outputs SHALL change only on a handshake.
REQ-020 mul_rst SHALL be 1 in IDLE and LOAD and 0 in RUN and DONE; the 0 in DONE holds the product stable.
REQ-021 LOAD SHALL last exactly one cycle, then go to RUN, with the cycle counter cleared to 0.
REQ-022 In RUN, the counter SHALL increment each cycle; when counter==LATENCY-1, the block SHALL register mul_product into resp_product and go to DONE.
REQ-023 The counter SHALL be $clog2(LATENCY+1) bits wide and SHALL never wrap.
REQ-024 In DONE, respn_valid SHALL be 1 only for the granted id; the other respn_valid SHALL stay 0.
REQ-025 While DONE is held, resp_product SHALL stay constant.
REQ-026 When the granted respn_ready is 1 in DONE, the block SHALL go DONE->IDLE in that cycle.
REQ-027 respn_ready of the non-granted requester SHALL be ignored.
REQ-028 respn_ready SHALL be ignored outside DONE.
REQ-029 Latency SHALL be exactly LATENCY+2 cycles: handshake in cycle T gives respn_valid=1 from cycle T+LATENCY+2.
REQ-030 A new request SHALL NOT be granted in the cycle DONE->IDLE is taken; the earliest next grant is the following cycle.
REQ-031 A reqn_valid deasserted without a handshake SHALL be dropped with no state change; a request that is not granted SHALL stay pending.
REQ-032 resp_product SHALL be the exact signed 64-bit product; the block SHALL perform no arithmetic on it.

Reset
REQ-033 While rst=1, asynchronously: state=IDLE, counter=0, last_grant=1 (req0 wins the first tie), operand registers=0, resp_product=0, mul_rst=1, and all valid/ready outputs 0 except the IDLE-derived reqn_ready.
REQ-034 rst asserted in any state, including mid-RUN or mid-DONE, SHALL abort the operation; the result SHALL be discarded and no respn_valid pulse SHALL be issued.

Verification
REQ-035 The bench SHALL cover a single request: req0 a=0x12345678, b=0x12345678 -> resp0_valid at T+14 (LATENCY=12), resp_product=0x014B66DC1DF4D840.
REQ-036 The bench SHALL cover a simultaneous request after reset: req0 (-1,-1) and req1 (0x7FFFFFFF,0x7FFFFFFF) -> req0 served first with product 1; req1 served next with product 0x3FFFFFFF00000001.
REQ-037 The bench SHALL cover back-to-back fairness: both valid for 4 transactions -> grant order 0,1,0,1, with no cycle where both reqn_ready are 1.
REQ-038 The bench SHALL cover backpressure: resp1_ready held 0 for 20 cycles after resp1_valid -> resp_product constant, mul_rst=0, and no grant to req0 until resp1_ready=1.
REQ-039 The bench SHALL cover MIN_INT: req1 a=0x80000000, b=0xFFFFFFFF -> resp_product=0x0000000080000000.
REQ-040 The bench SHALL cover reset mid-RUN: rst pulsed at counter=5 -> immediate IDLE, mul_rst=1, resp_product=0, and no respn_valid afterwards.
